systolic_tile_sched: RTL and testbench
======================================

# systolic_tile_sched

Tile scheduler for the N1×N2 systolic multiply array. On a `start` pulse it walks every output tile of an M×M × M×M product. For each tile it:
- issues the M-cycle operand read stream to the A and B buffers;
- waits out the array skew;
- hands the finished tile to the drain path over a valid/ready handshake.

It sits between the host/command logic and the operand buffers and PE array, and replaces free-running address counters with a start/done-sequenced walk.

## Interface
- `N1`, 4: PE array rows; A slice height; M/N1 A slices.
- `N2`, 4: PE array columns; B slice width; M/N2 B slices.
- `M`, 8: matrix dimension; power of two, multiple of N1 and N2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: begin a full product; sampled only in IDLE.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse after the last tile handshake.
- `rd_en` output 1: A and B buffer read enable; high only in STREAM.
- `rd_addr_A` output clog2(M*M/N1): equals k + i*M.
- `rd_addr_B` output clog2(M*M/N2): equals k + j*M.
- `clear_acc` output 1: PE accumulator clear; high on the first STREAM cycle of each tile.
- `tile_valid` output 1: finished tile available; high only in WAIT_OUT.
- `tile_ready` input 1: drain path accepts the tile.
- `tile_row` output max(clog2(M/N1),1): current A slice index i.
- `tile_col` output max(clog2(M/N2),1): current B slice index j.
- `stall_cycles` output 16: present only with `SCHED_PERF_CNT_EN`.

## Operation
- **Indices.**
  - k: 0..M-1, operand (pixel) index.
  - i: 0..M/N1-1, tile row.
  - j: 0..M/N2-1, tile column.
  - j is the inner loop and i the outer loop. Tile order is (0,0),(0,1)…(0,M/N2-1),(1,0)…
- **Address arithmetic.** Unsigned, computed in the output width; no overflow is possible.
- **Skew length.** D = N1+N2-1.
- **States:**
  - IDLE: all outputs low. `start`=1 sets i=j=k=0 and moves to STREAM.
  - STREAM: `rd_en`=1 and k increments each cycle. When k=M-1, k clears to 0 and the state moves to DRAIN.
  - DRAIN: counts D cycles, then moves to WAIT_OUT.
  - WAIT_OUT: `tile_valid`=1, with `tile_row`/`tile_col` held at the current i/j. When `tile_valid`&`tile_ready`:
    - if this is the last tile (i=M/N1-1 and j=M/N2-1), move to DONE;
    - otherwise advance j (wrapping to 0 and incrementing i), then move to STREAM.
  - DONE: `done`=1 for one cycle, then IDLE.
- `tile_row`/`tile_col` show the current i/j in STREAM, DRAIN and WAIT_OUT, and read 0 in IDLE.
- `start` outside IDLE is ignored and does not queue.
- `tile_ready` outside WAIT_OUT is ignored.
- While `tile_ready`=0, WAIT_OUT holds indefinitely and all outputs stay stable.
- Degenerate sizes:
  - M/N1=1: i is constantly 0.
  - M/N2=1: j is constantly 0.
  - M=N1=N2: single tile; DONE follows the first handshake.
- **Reset.** Asserting `rst` at any time, including mid-STREAM, immediately forces IDLE with i=j=k=0 and all outputs 0. No `done` is issued for an aborted product.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- `start` high at edge 0 puts the first STREAM cycle in cycle 1, carrying `clear_acc`=1, k=0 and `rd_addr_A`=`rd_addr_B`=0.
- Each tile takes M STREAM + D DRAIN + W WAIT_OUT cycles, where W ≥ 1 (W=1 when `tile_ready` is held high).
- After a handshake in cycle t, the next tile's STREAM starts in cycle t+1; there is no bubble.
- Defaults (M=8, N1=N2=4, `tile_ready`=1):
  - 4 tiles of 16 cycles each;
  - last handshake in cycle 64, `done` in cycle 65, IDLE (`busy`=0) in cycle 66.

## Configuration
- `SCHED_PERF_CNT_EN` defined:
  - adds `stall_cycles`, which counts cycles in WAIT_OUT with `tile_ready`=0;
  - it saturates at 16'hFFFF, clears to 0 on an accepted `start`, and holds its value after DONE;
  - its reset value is 0.
- Not defined: the port and its logic are absent, and scheduling behaviour is identical.

## Test plan
- Defaults, `start` pulse, `tile_ready` tied 1 → cycles 1–8:
  - `rd_addr_A` runs 0..7 and `rd_addr_B` 0..7;
  - `clear_acc` is high only in cycle 1;
  - `tile_valid` is high in cycle 16 with row=0, col=0;
  - `done` pulses in cycle 65.
- Full walk → A base addresses per tile are 0,0,8,8 and B base addresses 0,8,0,8. Tile order is (0,0),(0,1),(1,0),(1,1).
- Hold `tile_ready`=0 for 5 cycles on tile (0,1):
  - `tile_valid` and the indices hold stable;
  - `done` moves to cycle 70;
  - with `SCHED_PERF_CNT_EN`, `stall_cycles`=5.
- `start` pulses in STREAM and DRAIN → ignored; exactly one `done`, in cycle 65.
- `rst` low during cycle 20 (tile 1 STREAM):
  - all outputs are 0 that cycle, with no `done`;
  - a new `start` then restarts from tile (0,0) with addresses 0.
- M=N1=N2=4 → single tile: 4 STREAM cycles + 7 DRAIN cycles + handshake in cycle 12; `done` in cycle 13.

Source files
------------

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the N1 x N2 systolic array: walks every output tile of an
// M x M product, streams operand addresses, waits out the array skew and hands
// each finished tile to the drain path over valid/ready.
// Optional feature macro: SCHED_PERF_CNT_EN adds the stall_cycles counter.
module systolic_tile_sched #(
   parameter int unsigned N1 = 4,
   parameter int unsigned N2 = 4,
   parameter int unsigned M  = 8
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      rd_en,
   output logic [$clog2(M*M/N1)-1:0]                 rd_addr_A,
   output logic [$clog2(M*M/N2)-1:0]                 rd_addr_B,
   output logic                                      clear_acc,
   output logic                                      tile_valid,
   input  logic                                      tile_ready,
   output logic [((M/N1 > 1) ? $clog2(M/N1) : 1)-1:0] tile_row,
   output logic [((M/N2 > 1) ? $clog2(M/N2) : 1)-1:0] tile_col
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [15:0]                               stall_cycles
`endif
);

   localparam int unsigned AW_A   = $clog2(M*M/N1);
   localparam int unsigned AW_B   = $clog2(M*M/N2);
   localparam int unsigned RW     = (M/N1 > 1) ? $clog2(M/N1) : 1;
   localparam int unsigned CW     = (M/N2 > 1) ? $clog2(M/N2) : 1;
   localparam int unsigned KW     = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned D      = N1 + N2 - 1;
   localparam int unsigned DW     = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned I_LAST = M/N1 - 1;
   localparam int unsigned J_LAST = M/N2 - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_WAIT_OUT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [DW-1:0]   d_q, d_d;
   logic [RW-1:0]   i_q, i_d;
   logic [CW-1:0]   j_q, j_d;
   logic            show_idx;

   // State and walk-index registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         d_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         d_q     <= d_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

   // Next-state and index update: j inner loop, i outer loop
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      d_d     = d_q;
      i_d     = i_q;
      j_d     = j_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_STREAM;
               k_d     = '0;
               d_d     = '0;
               i_d     = '0;
               j_d     = '0;
            end
         end
         S_STREAM: begin
            if (k_q == KW'(M - 1)) begin
               k_d     = '0;
               d_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            if (d_q == DW'(D - 1)) begin
               d_d     = '0;
               state_d = S_WAIT_OUT;
            end else begin
               d_d = d_q + DW'(1);
            end
         end
         S_WAIT_OUT: begin
            if (tile_ready) begin
               if ((i_q == RW'(I_LAST)) && (j_q == CW'(J_LAST))) begin
                  state_d = S_DONE;
               end else begin
                  if (j_q == CW'(J_LAST)) begin
                     j_d = '0;
                     i_d = i_q + RW'(1);
                  end else begin
                     j_d = j_q + CW'(1);
                  end
                  state_d = S_STREAM;
               end
            end
         end
         S_DONE: begin
            i_d     = '0;
            j_d     = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded purely from registered state
   assign show_idx   = (state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_WAIT_OUT);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign rd_en      = (state_q == S_STREAM);
   assign clear_acc  = rd_en && (k_q == '0);
   assign tile_valid = (state_q == S_WAIT_OUT);
   assign tile_row   = show_idx ? i_q : '0;
   assign tile_col   = show_idx ? j_q : '0;
   assign rd_addr_A  = rd_en ? (AW_A'(k_q) + AW_A'(i_q) * AW_A'(M)) : '0;
   assign rd_addr_B  = rd_en ? (AW_B'(k_q) + AW_B'(j_q) * AW_B'(M)) : '0;

`ifdef SCHED_PERF_CNT_EN
   // Saturating count of WAIT_OUT cycles stalled by the drain path
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         stall_cycles <= '0;
      end else if ((state_q == S_WAIT_OUT) && !tile_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Bench for systolic_tile_sched: builds the expected cycle-by-cycle schedule
// from the tile-walk rules and compares both a default and a single-tile DUT.
module tb_systolic_tile_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, tile_ready;
   logic       busy, done, rd_en, clear_acc, tile_valid;
   logic [3:0] rd_addr_A, rd_addr_B;
   logic [0:0] tile_row, tile_col;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0] stall_cycles, stall_cycles2;
`endif

   logic       start2, ready2;
   logic       busy2, done2, rd_en2, clear_acc2, tile_valid2;
   logic [1:0] rd_addr_A2, rd_addr_B2;
   logic [0:0] tile_row2, tile_col2;

   systolic_tile_sched #(.N1(4), .N2(4), .M(8)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
      .clear_acc(clear_acc), .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_row(tile_row), .tile_col(tile_col)
`ifdef SCHED_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   systolic_tile_sched #(.N1(4), .N2(4), .M(4)) dut_single (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .rd_en(rd_en2), .rd_addr_A(rd_addr_A2), .rd_addr_B(rd_addr_B2),
      .clear_acc(clear_acc2), .tile_valid(tile_valid2), .tile_ready(ready2),
      .tile_row(tile_row2), .tile_col(tile_col2)
`ifdef SCHED_PERF_CNT_EN
      , .stall_cycles(stall_cycles2)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      bit start, ready, busy, rd_en, clr, valid, done;
      int addr_a, addr_b, row, col;
   } step_t;

   step_t tr[$];
   int    exp_stalls;
   int    done_at;

   // Expected schedule: idle+start, per tile M stream, D drain, stalls, handshake; done; idle
   task automatic build_trace(input int m, input int n1, input int n2, input int mode, input bit rnd_start);
      step_t s;
      int    st;
      tr.delete();
      exp_stalls = 0;
      s = '{default: 0};
      s.start = 1'b1;
      tr.push_back(s);
      for (int i = 0; i < m / n1; i++) begin
         for (int j = 0; j < m / n2; j++) begin
            for (int k = 0; k < m; k++) begin
               s = '{default: 0};
               s.busy = 1; s.rd_en = 1; s.clr = (k == 0);
               s.addr_a = k + i * m; s.addr_b = k + j * m;
               s.row = i; s.col = j;
               s.start = rnd_start && ($urandom_range(0, 2) == 0);
               s.ready = $urandom_range(0, 1);
               tr.push_back(s);
            end
            for (int d = 0; d < n1 + n2 - 1; d++) begin
               s = '{default: 0};
               s.busy = 1; s.row = i; s.col = j;
               s.start = rnd_start && ($urandom_range(0, 2) == 0);
               s.ready = $urandom_range(0, 1);
               tr.push_back(s);
            end
            st = (mode == 1) ? int'($urandom_range(0, 3)) :
                 ((mode == 2) && (i == 0) && (j == 1)) ? 5 : 0;
            for (int w = 0; w <= st; w++) begin
               s = '{default: 0};
               s.busy = 1; s.valid = 1; s.row = i; s.col = j;
               s.ready = (w == st);
               s.start = rnd_start && ($urandom_range(0, 2) == 0);
               tr.push_back(s);
            end
            exp_stalls += st;
         end
      end
      s = '{default: 0};
      s.busy = 1; s.done = 1;
      s.start = rnd_start && ($urandom_range(0, 1) == 0);
      s.ready = $urandom_range(0, 1);
      tr.push_back(s);
      s = '{default: 0};
      tr.push_back(s);
   endtask

   // Compare observed outputs with the schedule, driving inputs for each cycle
   task automatic run_trace(input bit sel, input string name, input int limit);
      logic [31:0] g_busy, g_rd, g_clr, g_val, g_done, g_a, g_b, g_row, g_col;
      done_at = -1;
      for (int c = 0; c < tr.size() && c < limit; c++) begin
         @(negedge clk);
         if (sel) begin
            g_busy = 32'(busy2); g_rd = 32'(rd_en2); g_clr = 32'(clear_acc2);
            g_val = 32'(tile_valid2); g_done = 32'(done2);
            g_a = 32'(rd_addr_A2); g_b = 32'(rd_addr_B2);
            g_row = 32'(tile_row2); g_col = 32'(tile_col2);
         end else begin
            g_busy = 32'(busy); g_rd = 32'(rd_en); g_clr = 32'(clear_acc);
            g_val = 32'(tile_valid); g_done = 32'(done);
            g_a = 32'(rd_addr_A); g_b = 32'(rd_addr_B);
            g_row = 32'(tile_row); g_col = 32'(tile_col);
         end
         if (g_done == 32'd1 && done_at < 0) done_at = c;
         check_val($sformatf("%s c%0d busy", name, c), g_busy, 32'(tr[c].busy));
         check_val($sformatf("%s c%0d rd_en", name, c), g_rd, 32'(tr[c].rd_en));
         check_val($sformatf("%s c%0d clear_acc", name, c), g_clr, 32'(tr[c].clr));
         check_val($sformatf("%s c%0d tile_valid", name, c), g_val, 32'(tr[c].valid));
         check_val($sformatf("%s c%0d done", name, c), g_done, 32'(tr[c].done));
         if (tr[c].rd_en || tr[c].valid || !tr[c].busy) begin
            check_val($sformatf("%s c%0d tile_row", name, c), g_row, 32'(tr[c].row));
            check_val($sformatf("%s c%0d tile_col", name, c), g_col, 32'(tr[c].col));
         end
         if (tr[c].rd_en || !tr[c].busy) begin
            check_val($sformatf("%s c%0d rd_addr_A", name, c), g_a, 32'(tr[c].addr_a));
            check_val($sformatf("%s c%0d rd_addr_B", name, c), g_b, 32'(tr[c].addr_b));
         end
         if (sel) begin
            start2 = tr[c].start;
            ready2 = 1'b1;
         end else begin
            start      = tr[c].start;
            tile_ready = tr[c].ready;
         end
      end
   endtask

   int exp_done;

   initial begin
      rst = 1'b0; start = 1'b0; tile_ready = 1'b0; start2 = 1'b0; ready2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset busy", 32'(busy), 32'd0);
      check_val("reset rd_en", 32'(rd_en), 32'd0);
      rst = 1'b1;

      // Default walk, ready held high, no stray starts
      build_trace(8, 4, 4, 0, 0);
      run_trace(1'b0, "base", 1000);
      check_val("base done cycle", 32'(done_at), 32'd65);
`ifdef SCHED_PERF_CNT_EN
      check_val("base stall_cycles", 32'(stall_cycles), 32'd0);
`endif

      // Five-cycle stall on tile (0,1), stray starts while busy
      build_trace(8, 4, 4, 2, 1);
      run_trace(1'b0, "stall5", 1000);
      check_val("stall5 done cycle", 32'(done_at), 32'd70);
`ifdef SCHED_PERF_CNT_EN
      check_val("stall5 stall_cycles", 32'(stall_cycles), 32'd5);
`endif

      // Reset asserted in cycle 20 (tile 1 STREAM), then a clean restart
      build_trace(8, 4, 4, 0, 0);
      run_trace(1'b0, "prerst", 20);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("abort busy", 32'(busy), 32'd0);
      check_val("abort rd_en", 32'(rd_en), 32'd0);
      check_val("abort done", 32'(done), 32'd0);
      check_val("abort clear_acc", 32'(clear_acc), 32'd0);
      check_val("abort tile_valid", 32'(tile_valid), 32'd0);
      check_val("abort rd_addr_A", 32'(rd_addr_A), 32'd0);
      check_val("abort rd_addr_B", 32'(rd_addr_B), 32'd0);
      check_val("abort tile_col", 32'(tile_col), 32'd0);
`ifdef SCHED_PERF_CNT_EN
      check_val("abort stall_cycles", 32'(stall_cycles), 32'd0);
`endif
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      build_trace(8, 4, 4, 0, 0);
      run_trace(1'b0, "restart", 1000);
      check_val("restart done cycle", 32'(done_at), 32'd65);

      // Randomised stalls and stray starts
      for (int t = 0; t < 3; t++) begin
         build_trace(8, 4, 4, 1, 1);
         exp_done = tr.size() - 2;
         run_trace(1'b0, $sformatf("rand%0d", t), 1000);
         check_val($sformatf("rand%0d done cycle", t), 32'(done_at), 32'(exp_done));
`ifdef SCHED_PERF_CNT_EN
         check_val($sformatf("rand%0d stall_cycles", t), 32'(stall_cycles), 32'(exp_stalls));
`endif
      end

      // Single-tile configuration M=N1=N2=4
      build_trace(4, 4, 4, 0, 0);
      run_trace(1'b1, "single", 1000);
      check_val("single done cycle", 32'(done_at), 32'd13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
